// File: rtl/axil_pkg.sv
// Shared AXI4-Lite constants and helpers for the register-file subordinate.
// Response encodings plus a ceiling-log2 used for byte-offset widths.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axil_regfile_subordinator_if.sv
// AXI4-Lite bus bundle between an interconnect manager port and a subordinate.
// Signal names follow the AXI channel names so an instance s_axi reads s_axi.AWADDR.
interface axil_regfile_subordinator_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    output ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID,
    input  ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    input  ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID,
    output ARREADY, RDATA, RRESP, RVALID
  );

endinterface

// File: rtl/axil_strb_reg.sv
// One data register with per-byte write enables.
// Bytes whose enable is low keep their current value.
module axil_strb_reg #(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   d_i,
  output logic [DATA_WIDTH-1:0]   q_o
);

  logic [DATA_WIDTH-1:0] q_q;
  logic [DATA_WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    for (int b = 0; b < DATA_WIDTH/8; b++) begin
      if (be_i[b]) q_d[b*8 +: 8] = d_i[b*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= RESET_VALUE;
    else     q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/axil_regfile_subordinator.sv
// AXI4-Lite subordinate backed by NUM_REGS strobed registers.
// AW/W captured independently, committed together; B and R held until accepted.
import axil_pkg::*;

module axil_regfile_subordinator #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    NUM_REGS    = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  axil_regfile_subordinator_if.slave     s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int SW   = DATA_WIDTH / 8;
  localparam int OFFW = clog2(SW);
  localparam int IDXW = ADDR_WIDTH - OFFW;

  if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_dw
    $error("DATA_WIDTH must be 32 or 64");
  end
  if (NUM_REGS < 1 || NUM_REGS > 256) begin : g_bad_nr
    $error("NUM_REGS must be 1..256");
  end

  logic            aw_full_q, aw_full_d;
  logic [IDXW-1:0] aw_idx_q, aw_idx_d;
  logic            w_full_q, w_full_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [SW-1:0]   w_strb_q, w_strb_d;
  logic            bvalid_q, bvalid_d;
  logic [1:0]      bresp_q, bresp_d;
  logic [NUM_REGS-1:0] pulse_q, pulse_d;

  logic            rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]      rresp_q, rresp_d;

  logic aw_hs, w_hs, ar_hs, arready;
  logic commit, aw_hit, ar_hit;
  logic [IDXW-1:0] ar_idx;
  logic [NUM_REGS-1:0] wr_sel;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] reg_val [NUM_REGS];
  logic unused_addr_bits;

  assign unused_addr_bits = ^{s_axi.AWADDR[OFFW-1:0],
                              s_axi.ARADDR[OFFW-1:0]};

  assign aw_hs   = s_axi.AWVALID && !aw_full_q;
  assign w_hs    = s_axi.WVALID && !w_full_q;
  assign arready = !rvalid_q || s_axi.RREADY;
  assign ar_hs   = s_axi.ARVALID && arready;
  assign ar_idx  = s_axi.ARADDR[ADDR_WIDTH-1:OFFW];

  assign aw_hit = aw_idx_q < IDXW'(NUM_REGS);
  assign ar_hit = ar_idx < IDXW'(NUM_REGS);

  // A pending B that is not being accepted blocks the commit.
  assign commit = aw_full_q && w_full_q
               && (!bvalid_q || s_axi.BREADY);

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_sel[i] = commit && aw_hit && (aw_idx_q == IDXW'(i));
    end
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDXW'(i)) rd_word = reg_val[i];
    end
  end

  always_comb begin
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    pulse_d   = wr_sel;
    if (bvalid_q && s_axi.BREADY) bvalid_d = 1'b0;
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = aw_hit ? RESP_OKAY : RESP_DECERR;
    end
    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_idx_d  = s_axi.AWADDR[ADDR_WIDTH-1:OFFW];
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = s_axi.WDATA;
      w_strb_d = s_axi.WSTRB;
    end
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && s_axi.RREADY) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = ar_hit ? rd_word : '0;
      rresp_d  = ar_hit ? RESP_OKAY : RESP_DECERR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      pulse_q   <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      aw_full_q <= aw_full_d;
      aw_idx_q  <= aw_idx_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      pulse_q   <= pulse_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    axil_strb_reg #(
      .DATA_WIDTH  (DATA_WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_reg (
      .clk  (clk),
      .rst  (rst),
      .be_i (w_strb_q & {SW{wr_sel[g]}}),
      .d_i  (w_data_q),
      .q_o  (reg_val[g])
    );
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = reg_val[g];
  end

  assign s_axi.AWREADY = !aw_full_q;
  assign s_axi.WREADY  = !w_full_q;
  assign s_axi.BVALID  = bvalid_q;
  assign s_axi.BRESP   = bresp_q;
  assign s_axi.ARREADY = arready;
  assign s_axi.RVALID  = rvalid_q;
  assign s_axi.RDATA   = rdata_q;
  assign s_axi.RRESP   = rresp_q;
  assign wr_pulse_o    = pulse_q;

endmodule

// File: tb/tb_axil_regfile_subordinator.sv
// Directed bench for the AXI4-Lite register-file subordinate.
// Each task drives one scenario and checks against hand-computed values.
module tb_axil_regfile_subordinator;

  logic clk;
  logic rst;
  logic [255:0] regs;
  logic [7:0]   pulse;
  int checks;
  int errors;
  logic [7:0] pulse_or;
  int pulse_cycles;
  logic [31:0] exp_r [8];

  axil_regfile_subordinator_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  axil_regfile_subordinator #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (32),
    .NUM_REGS    (8),
    .RESET_VALUE (32'h0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_axi      (bus.slave),
    .regs_o     (regs),
    .wr_pulse_o (pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (|pulse) begin
      pulse_or = pulse_or | pulse;
      pulse_cycles = pulse_cycles + 1;
    end
  end

  function automatic logic [255:0] model_flat();
    logic [255:0] f;
    for (int i = 0; i < 8; i++) f[i*32 +: 32] = exp_r[i];
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_pulse();
    pulse_or = '0;
    pulse_cycles = 0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [1:0] resp);
    bit aw_done, w_done, aw_hs, w_hs, got_b;
    aw_done = 0; w_done = 0; got_b = 0;
    bus.AWADDR = a; bus.WDATA = d; bus.WSTRB = s;
    bus.AWVALID = 1; bus.WVALID = 1;
    for (int n = 0; n < 20 && !(aw_done && w_done); n++) begin
      aw_hs = bus.AWVALID && bus.AWREADY;
      w_hs  = bus.WVALID && bus.WREADY;
      tick();
      if (aw_hs) begin aw_done = 1; bus.AWVALID = 0; end
      if (w_hs)  begin w_done = 1;  bus.WVALID = 0;  end
    end
    bus.AWVALID = 0; bus.WVALID = 0;
    bus.BREADY = 1;
    for (int n = 0; n < 20 && !got_b; n++) begin
      if (bus.BVALID) got_b = 1;
      else tick();
    end
    resp = bus.BRESP;
    checks++;
    if (!(aw_done && w_done && got_b)) begin
      errors++;
      $display("FAIL write_timeout addr=%h: aw=%0d w=%0d b=%0d required all 1",
               a, aw_done, w_done, got_b);
    end
    tick();
    bus.BREADY = 0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                         output logic [1:0] resp);
    bit ar_done, got_r;
    ar_done = 0; got_r = 0;
    bus.ARADDR = a; bus.ARVALID = 1;
    for (int n = 0; n < 20 && !ar_done; n++) begin
      if (bus.ARREADY) ar_done = 1;
      tick();
    end
    bus.ARVALID = 0;
    for (int n = 0; n < 20 && !got_r; n++) begin
      if (bus.RVALID) got_r = 1;
      else tick();
    end
    d = bus.RDATA; resp = bus.RRESP;
    checks++;
    if (!(ar_done && got_r)) begin
      errors++;
      $display("FAIL read_timeout addr=%h: ar=%0d r=%0d required both 1",
               a, ar_done, got_r);
    end
    bus.RREADY = 1;
    tick();
    bus.RREADY = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    tick(); tick();
    rst = 0;
    for (int i = 0; i < 8; i++) exp_r[i] = 32'h0;
    checks++;
    if ({bus.AWREADY, bus.WREADY, bus.ARREADY} !== 3'b111) begin
      errors++;
      $display("FAIL reset_ready: got %b required 111",
               {bus.AWREADY, bus.WREADY, bus.ARREADY});
    end
    checks++;
    if ({bus.BVALID, bus.RVALID, pulse} !== 10'b0) begin
      errors++;
      $display("FAIL reset_valid: got b=%b r=%b pulse=%h required 0",
               bus.BVALID, bus.RVALID, pulse);
    end
    checks++;
    if (regs !== 256'h0) begin
      errors++;
      $display("FAIL reset_regs: got %h required 0", regs);
    end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] d;
    logic [1:0] r;
    clr_pulse();
    bus.WDATA = 32'hDEADBEEF; bus.WSTRB = 4'hF; bus.WVALID = 1;
    tick();
    bus.WVALID = 0;
    checks++;
    if (bus.WREADY !== 1'b0 || bus.AWREADY !== 1'b1) begin
      errors++;
      $display("FAIL w_first_ready: got w=%b aw=%b required 0 1",
               bus.WREADY, bus.AWREADY);
    end
    tick(); tick();
    bus.AWADDR = 32'h4; bus.AWVALID = 1;
    tick();
    bus.AWVALID = 0;
    checks++;
    if (bus.BVALID !== 1'b0) begin
      errors++;
      $display("FAIL w_first_early_b: got %b required 0", bus.BVALID);
    end
    tick();
    exp_r[1] = 32'hDEADBEEF;
    checks++;
    if (bus.BVALID !== 1'b1 || bus.BRESP !== 2'b00) begin
      errors++;
      $display("FAIL w_first_b: got v=%b resp=%b required 1 00",
               bus.BVALID, bus.BRESP);
    end
    checks++;
    if (regs !== model_flat() || pulse !== 8'h02) begin
      errors++;
      $display("FAIL w_first_commit: got reg1=%h pulse=%h required deadbeef 02",
               regs[63:32], pulse);
    end
    bus.BREADY = 1;
    tick();
    bus.BREADY = 0;
    checks++;
    if (bus.BVALID !== 1'b0 || pulse !== 8'h00 || pulse_cycles !== 1) begin
      errors++;
      $display("FAIL w_first_after: got b=%b pulse=%h cycles=%0d required 0 00 1",
               bus.BVALID, pulse, pulse_cycles);
    end
    do_read(32'h4, d, r);
    checks++;
    if (d !== 32'hDEADBEEF || r !== 2'b00) begin
      errors++;
      $display("FAIL w_first_read: got %h/%b required deadbeef/00", d, r);
    end
  endtask

  task automatic test_strobes();
    logic [1:0] r;
    do_write(32'h0, 32'h11223344, 4'hF, r);
    do_write(32'h3, 32'hAABBCCDD, 4'b0101, r);
    exp_r[0] = 32'h11BB33DD;
    checks++;
    if (regs[31:0] !== 32'h11BB33DD || r !== 2'b00) begin
      errors++;
      $display("FAIL strobes: got %h/%b required 11bb33dd/00", regs[31:0], r);
    end
  endtask

  task automatic test_decode_error();
    logic [31:0] d;
    logic [1:0] r;
    clr_pulse();
    do_write(32'h20, 32'hCAFEF00D, 4'hF, r);
    checks++;
    if (r !== 2'b11) begin
      errors++;
      $display("FAIL decerr_bresp: got %b required 11", r);
    end
    checks++;
    if (regs !== model_flat() || pulse_or !== 8'h00) begin
      errors++;
      $display("FAIL decerr_side_effect: got pulses=%h regs=%h required 00 unchanged",
               pulse_or, regs);
    end
    do_read(32'h20, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b11) begin
      errors++;
      $display("FAIL decerr_read: got %h/%b required 0/11", d, r);
    end
    clr_pulse();
    do_write(32'hC, 32'hFFFFFFFF, 4'h0, r);
    checks++;
    if (r !== 2'b00 || regs !== model_flat() || pulse_or !== 8'h08) begin
      errors++;
      $display("FAIL zero_strb: got resp=%b pulses=%h reg3=%h required 00 08 0",
               r, pulse_or, regs[127:96]);
    end
  endtask

  task automatic test_backpressure();
    bus.BREADY = 0;
    bus.AWADDR = 32'h10; bus.WDATA = 32'h44440004; bus.WSTRB = 4'hF;
    bus.AWVALID = 1; bus.WVALID = 1;
    tick();
    bus.AWADDR = 32'h14; bus.WDATA = 32'h55550005;
    tick();
    exp_r[4] = 32'h44440004;
    checks++;
    if (bus.BVALID !== 1'b1 || regs[159:128] !== 32'h44440004) begin
      errors++;
      $display("FAIL bp_first_commit: got b=%b reg4=%h required 1 44440004",
               bus.BVALID, regs[159:128]);
    end
    tick();
    bus.AWVALID = 0; bus.WVALID = 0;
    for (int n = 0; n < 4; n++) tick();
    checks++;
    if ({bus.BVALID, bus.AWREADY, bus.WREADY} !== 3'b100 ||
        bus.BRESP !== 2'b00 || regs !== model_flat()) begin
      errors++;
      $display("FAIL bp_stall: got b=%b aw=%b w=%b reg5=%h required 1 0 0 0",
               bus.BVALID, bus.AWREADY, bus.WREADY, regs[191:160]);
    end
    bus.BREADY = 1;
    tick();
    exp_r[5] = 32'h55550005;
    checks++;
    if (bus.BVALID !== 1'b1 || regs !== model_flat() ||
        {bus.AWREADY, bus.WREADY} !== 2'b11) begin
      errors++;
      $display("FAIL bp_second_commit: got b=%b reg5=%h required 1 55550005",
               bus.BVALID, regs[191:160]);
    end
    tick();
    bus.BREADY = 0;
    checks++;
    if (bus.BVALID !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got %b required 0", bus.BVALID);
    end
  endtask

  task automatic test_same_edge();
    logic [31:0] d;
    logic [1:0] r;
    do_write(32'h8, 32'h1, 4'hF, r);
    bus.AWADDR = 32'h8; bus.WDATA = 32'h2; bus.WSTRB = 4'hF;
    bus.AWVALID = 1; bus.WVALID = 1;
    tick();
    bus.AWVALID = 0; bus.WVALID = 0;
    bus.ARADDR = 32'h8; bus.ARVALID = 1;
    tick();
    bus.ARVALID = 0;
    exp_r[2] = 32'h2;
    checks++;
    if (bus.RVALID !== 1'b1 || bus.RDATA !== 32'h1 || regs[95:64] !== 32'h2) begin
      errors++;
      $display("FAIL same_edge: got rv=%b rdata=%h reg2=%h required 1 1 2",
               bus.RVALID, bus.RDATA, regs[95:64]);
    end
    bus.BREADY = 1; bus.RREADY = 1;
    tick();
    bus.BREADY = 0; bus.RREADY = 0;
    do_read(32'h8, d, r);
    checks++;
    if (d !== 32'h2 || r !== 2'b00) begin
      errors++;
      $display("FAIL same_edge_reread: got %h/%b required 2/00", d, r);
    end
  endtask

  task automatic test_back_to_back();
    bus.RREADY = 1; bus.ARVALID = 1;
    bus.ARADDR = 32'h0;
    tick();
    checks++;
    if (bus.RVALID !== 1'b1 || bus.RDATA !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL b2b_0: got %b/%h required 1/11bb33dd", bus.RVALID, bus.RDATA);
    end
    bus.ARADDR = 32'h4;
    tick();
    checks++;
    if (bus.RVALID !== 1'b1 || bus.RDATA !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL b2b_1: got %b/%h required 1/deadbeef", bus.RVALID, bus.RDATA);
    end
    bus.ARADDR = 32'h10;
    tick();
    checks++;
    if (bus.RVALID !== 1'b1 || bus.RDATA !== 32'h44440004) begin
      errors++;
      $display("FAIL b2b_2: got %b/%h required 1/44440004", bus.RVALID, bus.RDATA);
    end
    bus.ARVALID = 0;
    tick();
    bus.RREADY = 0;
    checks++;
    if (bus.RVALID !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: got %b required 0", bus.RVALID);
    end
  endtask

  task automatic test_reset_mid();
    bus.AWADDR = 32'h0; bus.AWVALID = 1;
    tick();
    bus.AWVALID = 0;
    rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i < 8; i++) exp_r[i] = 32'h0;
    checks++;
    if (bus.AWREADY !== 1'b1 || bus.BVALID !== 1'b0 || regs !== model_flat()) begin
      errors++;
      $display("FAIL reset_mid: got aw=%b b=%b regs=%h required 1 0 0",
               bus.AWREADY, bus.BVALID, regs);
    end
    bus.WDATA = 32'h77; bus.WSTRB = 4'hF; bus.WVALID = 1;
    tick();
    bus.WVALID = 0;
    tick(); tick();
    checks++;
    if (bus.BVALID !== 1'b0 || regs !== model_flat()) begin
      errors++;
      $display("FAIL reset_mid_dropped_aw: got b=%b reg0=%h required 0 0",
               bus.BVALID, regs[31:0]);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    pulse_or = '0; pulse_cycles = 0;
    rst = 1;
    bus.AWADDR = '0; bus.AWVALID = 0;
    bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 0;
    bus.BREADY = 0;
    bus.ARADDR = '0; bus.ARVALID = 0;
    bus.RREADY = 0;
    test_reset();
    test_w_before_aw();
    test_strobes();
    test_decode_error();
    test_backpressure();
    test_same_edge();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_regfile_subordinator.md
# axil_regfile_subordinator

Parametrised AXI4-Lite subordinate backed by a register file, generalising the single-beat test subordinate used in the interconnect example. Accepts AW and W in any order, applies byte strobes, returns OKAY/DECERR responses and holds B and R until the manager accepts them. It sits behind an interconnect manager port and exposes all register contents plus a write-commit pulse to user logic.

## Interface
Parameters:
- DATA_WIDTH, 32, data bus width; must be 32 or 64.
- ADDR_WIDTH, 32, address bus width.
- NUM_REGS, 8, number of DATA_WIDTH registers; must be 1..256.
- RESET_VALUE, 0, reset value of every register (DATA_WIDTH bits).

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_axiAWADDR  in  ADDR_WIDTH  write address.
- s_axiAWVALID / s_axiAWREADY  in / out  1  AW handshake.
- s_axiWDATA  in  DATA_WIDTH  write data.
- s_axiWSTRB  in  DATA_WIDTH/8  byte enables.
- s_axiWVALID / s_axiWREADY  in / out  1  W handshake.
- s_axiBRESP  out  2  write response.
- s_axiBVALID / s_axiBREADY  out / in  1  B handshake.
- s_axiARADDR  in  ADDR_WIDTH  read address.
- s_axiARVALID / s_axiARREADY  in / out  1  AR handshake.
- s_axiRDATA  out  DATA_WIDTH  read data.
- s_axiRRESP  out  2  read response.
- s_axiRVALID / s_axiRREADY  out / in  1  R handshake.
- regs_o  out  NUM_REGS*DATA_WIDTH  flat register contents, reg i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- wr_pulse_o  out  NUM_REGS  one-cycle pulse per register on committed write.

## Operation
- Word index = ADDR[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)]; low byte-offset bits ignored. Index >= NUM_REGS -> decode error.
- Write path: AW holding register (aw_full) and W holding register (w_full), filled independently. AWREADY = !aw_full; WREADY = !w_full. Either order or simultaneous accepted.
- Commit when aw_full && w_full && (!BVALID || BREADY): bytes with WSTRB=1 written, others kept; wr_pulse_o[idx]=1 for one cycle; BVALID=1, BRESP=OKAY (2'b00); both holding registers cleared. Decode error: no register change, no pulse, BRESP=DECERR (2'b11). WSTRB=0 on a valid index: OKAY, no data change, pulse still fires.
- BVALID/BRESP stable until BREADY; cleared on handshake unless a new commit occurs same edge.
- Read path: ARREADY = !RVALID || RREADY. On AR handshake RDATA/RRESP/RVALID load next edge; out of range -> RDATA=0, RRESP=DECERR. RVALID/RDATA/RRESP stable until RREADY.
- Read and commit to the same register on the same edge: read returns pre-write value.
- Read and write paths fully independent; no ordering between them.

## Timing
- Reset (rst=1 at edge): all registers = RESET_VALUE; aw_full=w_full=0; AWREADY=WREADY=ARREADY=1; BVALID=RVALID=0; BRESP=RRESP=0; RDATA=0; wr_pulse_o=0. Reset mid-transaction drops captured AW/W and pending B/R without response.
- Write latency: last of AW/W handshakes at edge N -> register updated, BVALID=1 after edge N+1 (if B free).
- Read latency: AR handshake at edge N -> RVALID=1 after edge N; back-to-back reads at one per cycle with RREADY held high.
- Backpressure: BREADY=0 stalls commit; holding registers stay full, AWREADY/WREADY stay low. Throughput one write per 2 cycles.

## Structure
- Shared package axil_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11; byte-offset width function clog2.
- One sub-module: axil_strb_reg (one DATA_WIDTH register with per-byte strobed write enable, reset to RESET_VALUE), generated NUM_REGS times.

## Test plan
- Reset: hold rst 2 cycles -> AWREADY=WREADY=ARREADY=1, BVALID=RVALID=0, regs_o all RESET_VALUE.
- W before AW: WDATA=0xDEADBEEF at cycle 0, AWADDR=0x4 at cycle 3 -> BRESP=OKAY after cycle 4, regs_o reg1=0xDEADBEEF, wr_pulse_o=0x02 one cycle; read 0x4 returns 0xDEADBEEF.
- Strobes: reg0=0x11223344, write 0xAABBCCDD WSTRB=4'b0101 -> reg0=0x11BB33DD.
- Decode error: write and read addr 0x20 with NUM_REGS=8 -> BRESP=DECERR, RRESP=DECERR, RDATA=0, no regs_o change, wr_pulse_o=0.
- Backpressure: BREADY=0 for 5 cycles after commit -> BVALID held, second AW/W accepted once then AWREADY=WREADY=0; second commit on BREADY edge.
- Same-edge read/write of reg2 (old 0x1, new 0x2) -> RDATA=0x1, subsequent read 0x2.
